// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery datapath: operand width, sequencer
// state encoding and modular-op opcodes.
package mont_pkg;

  localparam int WIDTH = 1027;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_P1_REQ  = 3'd1,
    ST_P1_WAIT = 3'd2,
    ST_P2_REQ  = 3'd3,
    ST_P2_WAIT = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/mod_addsub_ctrl.sv
// Modular add/subtract sequencer: drives one or two mpadder passes and
// selects the reduced result (a +/- b) mod m for operands already below m.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | waiting for start; operands captured on accepted start
// ST_P1_REQ  | add_start high for pass 1 (a +/- b)
// ST_P1_WAIT | waiting for pass-1 add_done; decide single or two pass
// ST_P2_REQ  | add_start high for pass 2 (r1 - m for add, r1 + m for sub)
// ST_P2_WAIT | waiting for pass-2 add_done; select reduced result
// ST_DONE    | done pulse, result valid
module mod_addsub_ctrl
  import mont_pkg::*;
#(
  parameter int WIDTH = mont_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic             add_start,
  output logic             add_subtract,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH:0]   add_result,
  input  logic             add_done
);

  state_t           state_q, state_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] r1_q, r1_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic             add_sub_q, add_sub_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_ADD;
      m_q       <= '0;
      r1_q      <= '0;
      result_q  <= '0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      add_sub_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      m_q       <= m_d;
      r1_q      <= r1_d;
      result_q  <= result_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      add_sub_q <= add_sub_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    m_d       = m_q;
    r1_d      = r1_q;
    result_d  = result_q;
    add_a_d   = add_a_q;
    add_b_d   = add_b_q;
    add_sub_d = add_sub_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_P1_REQ;
          op_d      = op_sub;
          m_d       = in_m;
          add_a_d   = in_a;
          add_b_d   = in_b;
          add_sub_d = op_sub;
        end
      end

      ST_P1_REQ: state_d = ST_P1_WAIT;

      ST_P1_WAIT: begin
        if (add_done) begin
          r1_d = add_result[WIDTH-1:0];
          if (op_q == OP_SUB && !add_result[WIDTH]) begin
            result_d = add_result[WIDTH-1:0];
            state_d  = ST_DONE;
          end else begin
            // Low bits of r1 are exact for both cases: a+b < 2^WIDTH, and a
            // negative difference wraps so that adding m lands in [0, m).
            state_d   = ST_P2_REQ;
            add_a_d   = add_result[WIDTH-1:0];
            add_b_d   = m_q;
            add_sub_d = (op_q == OP_ADD);
          end
        end
      end

      ST_P2_REQ: state_d = ST_P2_WAIT;

      ST_P2_WAIT: begin
        if (add_done) begin
          if (op_q == OP_ADD && add_result[WIDTH])
            result_d = r1_q;
          else
            result_d = add_result[WIDTH-1:0];
          state_d = ST_DONE;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  assign result       = result_q;
  assign done         = (state_q == ST_DONE);
  assign busy         = (state_q != ST_IDLE);
  assign add_start    = (state_q == ST_P1_REQ) || (state_q == ST_P2_REQ);
  assign add_subtract = add_sub_q;
  assign add_a        = add_a_q;
  assign add_b        = add_b_q;

endmodule
